// File: rtl/cnn_pkg.sv
// Shared geometry constants and receiver state encoding for the CNN frame sink.
package cnn_pkg;

  localparam int IMG_W  = 30;
  localparam int IMG_H  = 30;
  localparam int PIX_W  = 8;
  localparam int N_PIX  = IMG_W * IMG_H;
  localparam int ADDR_W = $clog2(N_PIX);
  localparam int X_W    = $clog2(IMG_W);
  localparam int Y_W    = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    READY    = 2'd2,
    WAIT_GAP = 2'd3
  } rx_state_t;

endpackage

// File: rtl/cnn_frame_ram.sv
// Frame buffer: one write port, one registered read port. Out-of-range reads return 0.
module cnn_frame_ram
  import cnn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [N_PIX];
  logic [PIX_W-1:0] rd_data_q;

  // Write port; array has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read with range guard; only the output register is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_addr_i < ADDR_W'(N_PIX)) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/cnn_frame_receiver.sv
// Sink of the raster pixel stream: assembles one frame into the buffer and holds it
// for the CNN core until frame_ack.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | no frame in progress; first valid pixel starts a frame at addr 0
//   FILL     | writing pixels; a run of GAP_MAX valid-low cycles aborts
//   READY    | complete frame held, frame_valid=1; incoming pixels discarded
//   WAIT_GAP | frame released mid-burst; wait for valid to drop before IDLE
module cnn_frame_receiver
  import cnn_pkg::*;
#(
  parameter logic INVERT  = 1'b1,
  parameter int   GAP_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pixel_i,
  input  logic              pixel_i_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic              frame_drop
);

  localparam int GAP_W = $clog2(GAP_MAX + 1);

  rx_state_t          state_q, state_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               burst_open_q;
  logic               frame_valid_q;
  logic               frame_err_q, frame_err_d;
  logic               frame_drop_q, frame_drop_d;

  logic               wr_en;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               last_pix;
  logic               gap_timeout;
  logic               new_burst;

  assign wr_data     = INVERT ? ~pixel_i : pixel_i;
  assign last_pix    = (x_q == X_W'(IMG_W - 1)) && (y_q == Y_W'(IMG_H - 1));
  assign gap_timeout = (gap_cnt_q + GAP_W'(1)) == GAP_W'(GAP_MAX);
  assign new_burst   = pixel_i_valid && !burst_open_q;

  // State, position counters and registered output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      wr_addr_q     <= '0;
      gap_cnt_q     <= '0;
      burst_open_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_drop_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      wr_addr_q     <= wr_addr_d;
      gap_cnt_q     <= gap_cnt_d;
      burst_open_q  <= pixel_i_valid;
      frame_valid_q <= (state_d == READY);
      frame_err_q   <= frame_err_d;
      frame_drop_q  <= frame_drop_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pixel_i_valid) state_d = FILL;
      end
      FILL: begin
        if (pixel_i_valid) begin
          if (last_pix) state_d = READY;
        end else if (gap_timeout) begin
          state_d = IDLE;
        end
      end
      READY: begin
        // Ack takes priority over a simultaneous new burst.
        if (frame_ack) state_d = pixel_i_valid ? WAIT_GAP : IDLE;
      end
      WAIT_GAP: begin
        if (!pixel_i_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write strobe, counter updates and error/drop pulses.
  always_comb begin
    wr_en        = 1'b0;
    ram_wr_addr  = wr_addr_q;
    x_d          = x_q;
    y_d          = y_q;
    wr_addr_d    = wr_addr_q;
    gap_cnt_d    = gap_cnt_q;
    frame_err_d  = 1'b0;
    frame_drop_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (pixel_i_valid) begin
          wr_en       = 1'b1;
          ram_wr_addr = '0;
          x_d         = X_W'(1);
          y_d         = '0;
          wr_addr_d   = ADDR_W'(1);
        end
      end
      FILL: begin
        if (pixel_i_valid) begin
          wr_en     = 1'b1;
          gap_cnt_d = '0;
          if (last_pix) begin
            x_d       = '0;
            y_d       = '0;
            wr_addr_d = '0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
            if (x_q == X_W'(IMG_W - 1)) begin
              x_d = '0;
              y_d = y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
          end
        end else if (gap_timeout) begin
          frame_err_d = 1'b1;
          x_d         = '0;
          y_d         = '0;
          wr_addr_d   = '0;
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      READY: begin
        if (!frame_ack && new_burst) frame_drop_d = 1'b1;
      end
      WAIT_GAP: begin
      end
      default: begin
      end
    endcase
  end

  cnn_frame_ram u_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_drop  = frame_drop_q;

endmodule
